module_debounce_array: RTL and testbench

MODULE_DEBOUNCE_ARRAY -- requirements
Module: module_debounce_array

---
 rtl/debounce_pkg.sv | 18 +
 rtl/module_debounce_ch.sv | 167 ++++++++++++++++
 rtl/module_debounce_array.sv | 50 +++++
 tb/tb_module_debounce_array.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the button debounce array.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HELD    = 2'b01,
    ST_REPEAT  = 2'b10,
    ST_INHIBIT = 2'b11
  } state_e;

  localparam int DEF_NCH       = 4;
  localparam int DEF_N_STABLE  = 10;
  localparam int DEF_N_INHIBIT = 20;
  localparam int DEF_N_HOLD    = 22;
  localparam int DEF_N_REPEAT  = 20;
  localparam int DEF_REPEAT_EN = 1;

endpackage

// File: rtl/module_debounce_ch.sv
// Single button channel: two-flop synchroniser, stability/hold/repeat/inhibit
// counters and the press/hold/repeat/inhibit state machine.
module module_debounce_ch
  import debounce_pkg::*;
#(
  parameter int N_STABLE  = DEF_N_STABLE,
  parameter int N_INHIBIT = DEF_N_INHIBIT,
  parameter int N_HOLD    = DEF_N_HOLD,
  parameter int N_REPEAT  = DEF_N_REPEAT,
  parameter int REPEAT_EN = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_in,
  output logic db_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam bit REP_ON = (REPEAT_EN != 0);
  localparam logic [N_STABLE-1:0]  STAB_ZERO = {N_STABLE{1'b0}};
  localparam logic [N_STABLE-1:0]  STAB_ONE  = {{(N_STABLE-1){1'b0}}, 1'b1};
  localparam logic [N_HOLD-1:0]    HOLD_ZERO = {N_HOLD{1'b0}};
  localparam logic [N_HOLD-1:0]    HOLD_ONE  = {{(N_HOLD-1){1'b0}}, 1'b1};
  localparam logic [N_REPEAT-1:0]  REP_ZERO  = {N_REPEAT{1'b0}};
  localparam logic [N_REPEAT-1:0]  REP_ONE   = {{(N_REPEAT-1){1'b0}}, 1'b1};
  localparam logic [N_INHIBIT-1:0] INH_ZERO  = {N_INHIBIT{1'b0}};
  localparam logic [N_INHIBIT-1:0] INH_ONE   = {{(N_INHIBIT-1){1'b0}}, 1'b1};

  logic                 sync1_r, sync2_r;
  logic [N_STABLE-1:0]  stab_cnt_r;
  logic [N_HOLD-1:0]    hold_cnt_r, hold_nxt_s, hold_inc_s;
  logic [N_REPEAT-1:0]  rep_cnt_r, rep_nxt_s, rep_inc_s;
  logic [N_INHIBIT-1:0] inh_cnt_r, inh_nxt_s, inh_inc_s;
  state_e               state_r, state_nxt_s;
  logic                 db_nxt_s, press_nxt_s, release_nxt_s, repeat_nxt_s;
  logic                 diff_s, stable_high_s, stable_low_s, hold_hit_s, rep_hit_s, inh_msb_s;

  assign diff_s        = sync1_r ^ sync2_r;
  assign stable_high_s = stab_cnt_r[N_STABLE-1] & sync2_r;
  assign stable_low_s  = stab_cnt_r[N_STABLE-1] & ~sync2_r;
  assign hold_inc_s    = hold_cnt_r + HOLD_ONE;
  assign rep_inc_s     = rep_cnt_r + REP_ONE;
  assign inh_inc_s     = inh_cnt_r + INH_ONE;
  // "MSB sets" means this cycle's increment is the one that reaches it
  assign hold_hit_s    = ~hold_cnt_r[N_HOLD-1] & hold_inc_s[N_HOLD-1];
  assign rep_hit_s     = ~rep_cnt_r[N_REPEAT-1] & rep_inc_s[N_REPEAT-1];
  assign inh_msb_s     = inh_cnt_r[N_INHIBIT-1];

  // Synchroniser and saturating stability counter
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stab_cnt_r <= STAB_ZERO;
    end else begin
      sync1_r <= button_in;
      sync2_r <= sync1_r;
      if (diff_s) begin
        stab_cnt_r <= STAB_ZERO;
      end else if (!stab_cnt_r[N_STABLE-1]) begin
        stab_cnt_r <= stab_cnt_r + STAB_ONE;
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_cnt_r;
    rep_nxt_s     = rep_cnt_r;
    inh_nxt_s     = inh_cnt_r;
    db_nxt_s      = 1'b0;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    repeat_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stable_high_s) begin
          state_nxt_s = ST_HELD;
          hold_nxt_s  = HOLD_ZERO;
          press_nxt_s = 1'b1;
          db_nxt_s    = 1'b1;
        end else begin
          db_nxt_s = 1'b0;
        end
      end
      ST_HELD: begin
        db_nxt_s = 1'b1;
        if (stable_low_s) begin
          state_nxt_s   = ST_INHIBIT;
          inh_nxt_s     = INH_ZERO;
          release_nxt_s = 1'b1;
          db_nxt_s      = 1'b0;
        end else if (REP_ON && hold_hit_s) begin
          state_nxt_s  = ST_REPEAT;
          hold_nxt_s   = hold_inc_s;
          rep_nxt_s    = REP_ZERO;
          repeat_nxt_s = 1'b1;
        end else if (!hold_cnt_r[N_HOLD-1]) begin
          hold_nxt_s = hold_inc_s;
        end else begin
          hold_nxt_s = hold_cnt_r;
        end
      end
      ST_REPEAT: begin
        db_nxt_s = 1'b1;
        if (stable_low_s) begin
          state_nxt_s   = ST_INHIBIT;
          inh_nxt_s     = INH_ZERO;
          release_nxt_s = 1'b1;
          db_nxt_s      = 1'b0;
        end else if (rep_hit_s) begin
          rep_nxt_s    = REP_ZERO;
          repeat_nxt_s = 1'b1;
        end else begin
          rep_nxt_s = rep_inc_s;
        end
      end
      ST_INHIBIT: begin
        db_nxt_s = 1'b0;
        if (inh_msb_s && !sync2_r) begin
          state_nxt_s = ST_IDLE;
        end else if (diff_s) begin
          inh_nxt_s = INH_ZERO;
        end else if (!inh_msb_s) begin
          inh_nxt_s = inh_inc_s;
        end else begin
          inh_nxt_s = inh_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hold_nxt_s  = HOLD_ZERO;
        rep_nxt_s   = REP_ZERO;
        inh_nxt_s   = INH_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r       <= ST_IDLE;
      hold_cnt_r    <= HOLD_ZERO;
      rep_cnt_r     <= REP_ZERO;
      inh_cnt_r     <= INH_ZERO;
      db_level      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      hold_cnt_r    <= hold_nxt_s;
      rep_cnt_r     <= rep_nxt_s;
      inh_cnt_r     <= inh_nxt_s;
      db_level      <= db_nxt_s;
      press_pulse   <= press_nxt_s;
      release_pulse <= release_nxt_s;
      repeat_pulse  <= repeat_nxt_s;
    end
  end

endmodule

// File: rtl/module_debounce_array.sv
// Array of NCH independent debounced button channels plus a registered
// any-press flag.
module module_debounce_array
  import debounce_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int N_STABLE  = DEF_N_STABLE,
  parameter int N_INHIBIT = DEF_N_INHIBIT,
  parameter int N_HOLD    = DEF_N_HOLD,
  parameter int N_REPEAT  = DEF_N_REPEAT,
  parameter int REPEAT_EN = DEF_REPEAT_EN
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [NCH-1:0] button_in,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] press_pulse,
  output logic [NCH-1:0] release_pulse,
  output logic [NCH-1:0] repeat_pulse,
  output logic           any_press
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    module_debounce_ch #(
      .N_STABLE  (N_STABLE),
      .N_INHIBIT (N_INHIBIT),
      .N_HOLD    (N_HOLD),
      .N_REPEAT  (N_REPEAT),
      .REPEAT_EN (REPEAT_EN)
    ) u_ch (
      .clk           (clk),
      .n_reset       (n_reset),
      .button_in     (button_in[g]),
      .db_level      (db_level[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .repeat_pulse  (repeat_pulse[g])
    );
  end

  // One-cycle-delayed OR of all press pulses
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_pulse;
    end
  end

endmodule

// File: tb/tb_module_debounce_array.sv
// Directed and random checks of the debounce array against a window-based
// reference model; two instances cover auto-repeat enabled and disabled.
module tb_module_debounce_array;

  localparam int NCH  = 4;
  localparam int NS   = 4;
  localparam int NI   = 4;
  localparam int NH   = 6;
  localparam int NR   = 4;
  localparam int S    = 2 ** (NS - 1);
  localparam int I    = 2 ** (NI - 1);
  localparam int H    = 2 ** (NH - 1);
  localparam int R    = 2 ** (NR - 1);
  localparam int MAXT = 8192;
  localparam int M_IDLE = 0, M_HELD = 1, M_REP = 2, M_INH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           n_reset;
  logic [NCH-1:0] button_in;
  logic [NCH-1:0] db_a, pr_a, rl_a, rp_a, db_b, pr_b, rl_b, rp_b;
  logic           any_a, any_b;

  module_debounce_array #(.NCH(NCH), .N_STABLE(NS), .N_INHIBIT(NI), .N_HOLD(NH),
                          .N_REPEAT(NR), .REPEAT_EN(1)) u_dut_a (
    .clk(clk), .n_reset(n_reset), .button_in(button_in), .db_level(db_a),
    .press_pulse(pr_a), .release_pulse(rl_a), .repeat_pulse(rp_a), .any_press(any_a));

  module_debounce_array #(.NCH(NCH), .N_STABLE(NS), .N_INHIBIT(NI), .N_HOLD(NH),
                          .N_REPEAT(NR), .REPEAT_EN(0)) u_dut_b (
    .clk(clk), .n_reset(n_reset), .button_in(button_in), .db_level(db_b),
    .press_pulse(pr_b), .release_pulse(rl_b), .repeat_pulse(rp_b), .any_press(any_b));

  int errors = 0;
  int checks = 0;

  // Reference model: raw input history plus event timestamps per channel
  bit             hist [NCH][MAXT];
  int             since = 0;
  int             t = 2;
  int             st   [2][NCH];
  int             ent  [2][NCH];
  int             rlast[2][NCH];
  int             ient [2][NCH];
  logic [NCH-1:0] e_db [2];
  logic [NCH-1:0] e_pr [2];
  logic [NCH-1:0] e_rl [2];
  logic [NCH-1:0] e_rp [2];
  logic           e_any[2];

  // True when the len+1 synchronised samples ending two edges back all agree
  function automatic bit window_eq(int ch, int tt, int len);
    int lo;
    lo = tt - 2 - len;
    if (lo < since) return 1'b0;
    for (int i = lo; i <= tt - 2; i++)
      if (hist[ch][i] != hist[ch][tt-2]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit lvl, stab, sh, sl;
    t++;
    if (!n_reset) begin
      since = t - 1;
      for (int ch = 0; ch < NCH; ch++) begin
        hist[ch][t] = 1'b0;
        hist[ch][t-1] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < NCH; ch++) st[d][ch] = M_IDLE;
        e_db[d] = '0; e_pr[d] = '0; e_rl[d] = '0; e_rp[d] = '0; e_any[d] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) hist[ch][t] = button_in[ch];
      for (int d = 0; d < 2; d++) begin
        e_any[d] = |e_pr[d];
        e_pr[d] = '0; e_rl[d] = '0; e_rp[d] = '0;
        for (int ch = 0; ch < NCH; ch++) begin
          lvl  = hist[ch][t-2];
          stab = window_eq(ch, t, S);
          sh   = stab && lvl;
          sl   = stab && !lvl;
          case (st[d][ch])
            M_IDLE:
              if (sh) begin st[d][ch] = M_HELD; ent[d][ch] = t; e_pr[d][ch] = 1'b1; end
            M_HELD:
              if (sl) begin st[d][ch] = M_INH; ient[d][ch] = t; e_rl[d][ch] = 1'b1; end
              else if (d == 0 && t - ent[d][ch] == H) begin
                st[d][ch] = M_REP; rlast[d][ch] = t; e_rp[d][ch] = 1'b1;
              end
            M_REP:
              if (sl) begin st[d][ch] = M_INH; ient[d][ch] = t; e_rl[d][ch] = 1'b1; end
              else if (t - rlast[d][ch] == R) begin rlast[d][ch] = t; e_rp[d][ch] = 1'b1; end
            default:
              if (t - 1 - ient[d][ch] >= I && window_eq(ch, t, I) && !lvl) st[d][ch] = M_IDLE;
          endcase
          e_db[d][ch] = (st[d][ch] == M_HELD) || (st[d][ch] == M_REP);
        end
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("a_db",  {28'd0, db_a}, {28'd0, e_db[0]});
    cmp("a_pr",  {28'd0, pr_a}, {28'd0, e_pr[0]});
    cmp("a_rl",  {28'd0, rl_a}, {28'd0, e_rl[0]});
    cmp("a_rp",  {28'd0, rp_a}, {28'd0, e_rp[0]});
    cmp("a_any", {31'd0, any_a}, {31'd0, e_any[0]});
    cmp("b_db",  {28'd0, db_b}, {28'd0, e_db[1]});
    cmp("b_pr",  {28'd0, pr_b}, {28'd0, e_pr[1]});
    cmp("b_rl",  {28'd0, rl_b}, {28'd0, e_rl[1]});
    cmp("b_rp",  {28'd0, rp_b}, {28'd0, e_rp[1]});
    cmp("b_any", {31'd0, any_b}, {31'd0, e_any[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int press_at, rel_at, any_at, cnt_a, cnt_b, n_rel;
    int q[$];
    int dur[NCH];
    n_reset   = 1'b0;
    button_in = '0;

    // Reset state
    repeat (3) tick();
    cmp("reset_outputs", {15'd0, db_a, pr_a, rl_a, rp_a, any_a}, 32'd0);
    n_reset = 1'b1;
    repeat (20) tick();

    // Clean press on ch0: latency, then long hold with auto-repeat
    button_in[0] = 1'b1;
    press_at = -1; cnt_b = 0;
    for (int k = 1; k <= 71; k++) begin
      tick();
      if (pr_a[0] && press_at < 0) press_at = k;
      if (rp_a[0]) q.push_back(k);
      if (rp_b[0]) cnt_b++;
    end
    cmp("press_latency", press_at, 11);
    cmp("repeat_count", q.size(), 4);
    if (q.size() >= 2) begin
      cmp("first_repeat_gap", q[0] - press_at, 32);
      cmp("repeat_period", q[1] - q[0], 8);
    end
    cmp("db_held", {31'd0, db_a[0]}, 32'd1);
    cmp("no_repeat_when_disabled", cnt_b, 0);

    // Short glitch on ch1
    button_in[1] = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 5) button_in[1] = 1'b0;
      tick();
      cnt_a += pr_a[1] + rl_a[1] + rp_a[1] + db_a[1] + pr_b[1] + rl_b[1] + db_b[1];
    end
    cmp("glitch_quiet", cnt_a, 0);

    // Release ch0, re-press during inhibit
    button_in[0] = 1'b0;
    rel_at = -1;
    for (int k = 1; k <= 20 && rel_at < 0; k++) begin
      tick();
      if (rl_a[0]) rel_at = k;
    end
    cmp("release_latency", rel_at, 11);
    repeat (3) tick();
    button_in[0] = 1'b1;
    cnt_a = 0; n_rel = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt_a += pr_a[0];
      n_rel += rl_a[0];
    end
    cmp("inhibit_ignores_press", cnt_a, 0);
    cmp("single_release", n_rel, 0);
    cmp("inhibit_db_low", {31'd0, db_a[0]}, 32'd0);
    button_in[0] = 1'b0;
    repeat (25) tick();
    button_in[0] = 1'b1;
    press_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pr_a[0] && press_at < 0) press_at = k;
    end
    cmp("press_after_inhibit", press_at, 11);
    button_in[0] = 1'b0;
    repeat (30) tick();

    // Simultaneous press on ch0 and ch3
    button_in[0] = 1'b1;
    button_in[3] = 1'b1;
    press_at = -1; any_at = -1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (pr_a == 4'b1001 && press_at < 0) press_at = k;
      if (any_a && any_at < 0) any_at = k;
    end
    cmp("dual_press", press_at, 11);
    cmp("any_press_delay", any_at, 12);

    // Reset while repeating, input stays high
    repeat (50) tick();
    n_reset = 1'b0;
    tick();
    cmp("mid_reset_outputs", {15'd0, db_a, pr_a, rl_a, rp_a, any_a}, 32'd0);
    n_reset = 1'b1;
    press_at = -1; n_rel = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (pr_a[0] && press_at < 0) press_at = k;
      n_rel += rl_a[0] + rl_a[3];
    end
    cmp("press_after_reset", press_at, 11);
    cmp("no_release_on_reset", n_rel, 0);

    // Random traffic with occasional resets
    for (int ch = 0; ch < NCH; ch++) dur[ch] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (dur[ch] == 0) begin
          button_in[ch] = 1'($urandom_range(0, 1));
          dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7))
                                                : int'($urandom_range(8, 60));
        end
        dur[ch]--;
      end
      n_reset = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
